// File: rtl/al422_bam_pkg.sv
// Shared types and defaults for the AL422 BAM plane sequencer.
// The optional frame-sync stall is enabled by defining AL422_BAM_SEQ_VSYNC_EN.
package al422_bam_pkg;

  localparam int DEF_BITS_IN_COUNTER = 3;
  localparam int DEF_ROW_BITS        = 4;
  localparam int DEF_LATCH_WIDTH     = 2;
  localparam int NPLANES             = 1 << DEF_BITS_IN_COUNTER;
  localparam int NROWS               = 1 << DEF_ROW_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SH_START = 3'd1,
    SH_ACK   = 3'd2,
    SH_WAIT  = 3'd3,
    OE_WAIT  = 3'd4,
    LATCH    = 3'd5,
    OE_START = 3'd6,
    VS_WAIT  = 3'd7
  } state_t;

endpackage

// File: rtl/al422_bam_plane_counter.sv
// Row/plane counter for the pair being shifted; the plane field is the inner loop.
// Used by al422_bam_plane_sequencer (see AL422_BAM_SEQ_VSYNC_EN there).
module al422_bam_plane_counter
  import al422_bam_pkg::*;
#(
  parameter int BITS_IN_COUNTER = DEF_BITS_IN_COUNTER,
  parameter int ROW_BITS        = DEF_ROW_BITS
) (
  input  logic                       in_clk,
  input  logic                       in_nrst,
  input  logic                       advance,
  input  logic                       clear,
  output logic [ROW_BITS-1:0]        row,
  output logic [BITS_IN_COUNTER-1:0] plane,
  output logic                       frame_end
);

  localparam int PW = ROW_BITS + BITS_IN_COUNTER;

  logic [PW-1:0] pair_r;

  // Concatenated {row, plane} counter: a plane carry bumps the row, and the whole pair wraps naturally
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      pair_r <= {PW{1'b0}};
    end else if (clear) begin
      pair_r <= {PW{1'b0}};
    end else if (advance) begin
      pair_r <= pair_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  assign row       = pair_r[PW-1:BITS_IN_COUNTER];
  assign plane     = pair_r[BITS_IN_COUNTER-1:0];
  assign frame_end = &pair_r;

endmodule

// File: rtl/al422_bam_plane_sequencer.sv
// BAM (row, plane) sequencer: shifts the next plane while the current one is shown, then latches and starts OE.
// Define AL422_BAM_SEQ_VSYNC_EN to add the vsync input and hold between frames until a frame sync.
module al422_bam_plane_sequencer
  import al422_bam_pkg::*;
#(
  parameter int BITS_IN_COUNTER = DEF_BITS_IN_COUNTER,
  parameter int ROW_BITS        = DEF_ROW_BITS,
  parameter int LATCH_WIDTH     = DEF_LATCH_WIDTH
) (
  input  logic                       in_clk,
  input  logic                       in_nrst,
  input  logic                       enable,
  output logic                       shifter_start,
  input  logic                       shifter_busy,
  output logic [ROW_BITS-1:0]        shift_row,
  output logic [BITS_IN_COUNTER-1:0] shift_bit,
  output logic                       oe_start,
  input  logic                       oe_busy,
  output logic [BITS_IN_COUNTER-1:0] bit_counter,
  output logic [ROW_BITS-1:0]        row_addr,
  output logic                       led_lat,
`ifdef AL422_BAM_SEQ_VSYNC_EN
  input  logic                       vsync,
`endif
  output logic                       frame_done
);

  localparam int LCW = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;
  localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_WIDTH - 1);

  state_t         state_r;
  state_t         state_s;
  logic [LCW-1:0] latch_cnt_r;
  logic           frame_end_s;
  logic           advance_s;
  logic           clear_s;

  al422_bam_plane_counter #(
    .BITS_IN_COUNTER(BITS_IN_COUNTER),
    .ROW_BITS       (ROW_BITS)
  ) u_shift_cnt (
    .in_clk   (in_clk),
    .in_nrst  (in_nrst),
    .advance  (advance_s),
    .clear    (clear_s),
    .row      (shift_row),
    .plane    (shift_bit),
    .frame_end(frame_end_s)
  );

`ifdef AL422_BAM_SEQ_VSYNC_EN
  logic vs_flag_r;

  // Remember a frame sync that arrives before the frame has finished
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      vs_flag_r <= 1'b0;
    end else if (((state_r == VS_WAIT) && (state_s != VS_WAIT)) ||
                 ((state_s == IDLE) && (state_r != IDLE))) begin
      vs_flag_r <= 1'b0;
    end else if (vsync) begin
      vs_flag_r <= 1'b1;
    end
  end
`endif

  // Next-state logic for the start/busy handshake with the shifter and OE processor
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (enable) state_s = SH_START; else state_s = IDLE;
      SH_START: state_s = SH_ACK;
      SH_ACK:   state_s = SH_WAIT;
      SH_WAIT:  if (!shifter_busy) state_s = OE_WAIT; else state_s = SH_WAIT;
      OE_WAIT:  if (!oe_busy) state_s = LATCH; else state_s = OE_WAIT;
      LATCH:    if (latch_cnt_r == LATCH_LAST) state_s = OE_START; else state_s = LATCH;
      OE_START: begin
        if (!enable) state_s = IDLE;
`ifdef AL422_BAM_SEQ_VSYNC_EN
        else if (frame_end_s) state_s = VS_WAIT;
`endif
        else state_s = SH_START;
      end
`ifdef AL422_BAM_SEQ_VSYNC_EN
      VS_WAIT:  if (vsync || vs_flag_r) state_s = SH_START; else state_s = VS_WAIT;
`else
      VS_WAIT:  state_s = IDLE;
`endif
      default:  state_s = IDLE;
    endcase
  end

  assign advance_s = (state_r == OE_START);
  assign clear_s   = (state_r == OE_START) && (state_s == IDLE);

  // State register and latch-width counter
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_r     <= IDLE;
      latch_cnt_r <= {LCW{1'b0}};
    end else begin
      state_r     <= state_s;
      latch_cnt_r <= (state_r == LATCH) ? latch_cnt_r + LCW'(1) : {LCW{1'b0}};
    end
  end

  // Registered strobes decoded from the next state; display pair captured on LATCH entry
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      shifter_start <= 1'b0;
      oe_start      <= 1'b0;
      led_lat       <= 1'b0;
      frame_done    <= 1'b0;
      row_addr      <= {ROW_BITS{1'b0}};
      bit_counter   <= {BITS_IN_COUNTER{1'b0}};
    end else begin
      shifter_start <= (state_s == SH_START);
      oe_start      <= (state_s == OE_START);
      led_lat       <= (state_s == LATCH);
      frame_done    <= (state_s == OE_START) && frame_end_s;
      if ((state_r == OE_WAIT) && (state_s == LATCH)) begin
        row_addr    <= shift_row;
        bit_counter <= shift_bit;
      end
    end
  end

endmodule

// File: tb/tb_al422_bam_plane_sequencer.sv
// Self-checking bench for al422_bam_plane_sequencer with shifter/OE busy models and a pair-sequence reference.
// Define AL422_BAM_SEQ_VSYNC_EN to also exercise the frame-sync stall.
`timescale 1ns/1ps
module tb_al422_bam_plane_sequencer;
  import al422_bam_pkg::*;

  localparam int BW = 3, RW = 4, LW = 2, SH_BUSY = 10;
  localparam int NP = NPLANES, NPAIRS = NPLANES * NROWS;
`ifdef AL422_BAM_SEQ_VSYNC_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 1;
`endif

  logic in_clk = 1'b0, in_nrst, enable;
  logic shifter_busy = 1'b0, oe_busy = 1'b0;
  logic shifter_start, oe_start, led_lat, frame_done;
  logic [RW-1:0] shift_row, row_addr;
  logic [BW-1:0] shift_bit, bit_counter;
`ifdef AL422_BAM_SEQ_VSYNC_EN
  logic vsync = 1'b0;
`endif

  int checks = 0, failures = 0;
  int sh_cnt = 0, oe_cnt = 0, oe_fix = 0, lat_run = 0;
  int overlap_cnt = 0, oe_busy_cnt = 0, stray_fd_cnt = 0;
  int shift_log[$], shift_oebusy[$], shift_cyc[$], oe_log[$], oe_cyc[$], lat_widths[$];
  int cyc = 0;

  always #5 in_clk = ~in_clk;

  al422_bam_plane_sequencer #(.BITS_IN_COUNTER(BW), .ROW_BITS(RW), .LATCH_WIDTH(LW)) dut (
    .in_clk(in_clk), .in_nrst(in_nrst), .enable(enable),
    .shifter_start(shifter_start), .shifter_busy(shifter_busy),
    .shift_row(shift_row), .shift_bit(shift_bit),
    .oe_start(oe_start), .oe_busy(oe_busy),
    .bit_counter(bit_counter), .row_addr(row_addr), .led_lat(led_lat),
`ifdef AL422_BAM_SEQ_VSYNC_EN
    .vsync(vsync),
`endif
    .frame_done(frame_done)
  );

  // Observers plus shifter (fixed busy) and OE (random or fixed busy) models
  always @(negedge in_clk) begin
    cyc++;
    if (!in_nrst) begin
      sh_cnt = 0; oe_cnt = 0; lat_run = 0;
    end else begin
      if (shifter_start) begin
        shift_log.push_back(int'(shift_row) * NP + int'(shift_bit));
        shift_oebusy.push_back(int'(oe_busy));
        shift_cyc.push_back(cyc);
      end
      if (oe_start) begin
        oe_log.push_back(int'(row_addr) * NP + int'(bit_counter) + (frame_done ? 1000 : 0));
        oe_cyc.push_back(cyc);
        if (oe_busy) oe_busy_cnt++;
      end
      if (frame_done && !oe_start) stray_fd_cnt++;
      if (led_lat && oe_busy) overlap_cnt++;
      if (led_lat) lat_run++;
      else if (lat_run > 0) begin lat_widths.push_back(lat_run); lat_run = 0; end
      if (sh_cnt > 0) sh_cnt--;
      if (shifter_start) sh_cnt = SH_BUSY;
      if (oe_cnt > 0) oe_cnt--;
      if (oe_start) oe_cnt = (oe_fix != 0) ? oe_fix : int'($urandom_range(20, 1));
    end
    shifter_busy = (sh_cnt != 0);
    oe_busy      = (oe_cnt != 0);
  end

  task automatic clear_logs();
    shift_log.delete(); shift_oebusy.delete(); shift_cyc.delete();
    oe_log.delete(); oe_cyc.delete(); lat_widths.delete();
    overlap_cnt = 0; oe_busy_cnt = 0; stray_fd_cnt = 0;
  endtask

  task automatic do_reset();
    in_nrst = 1'b0; enable = 1'b0; oe_fix = 0;
    repeat (3) @(negedge in_clk);
    @(posedge in_clk); #1 in_nrst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_shifts(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge in_clk); #1;
      ok = (shift_log.size() >= n);
    end
  endtask

  task automatic wait_oes(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge in_clk); #1;
      ok = (oe_log.size() >= n);
    end
  endtask

  task automatic test_reset();
    in_nrst = 1'b0; enable = 1'b0;
    #3;
    checks++; if ({shifter_start, oe_start, led_lat, frame_done} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes: got %b expected 0000", {shifter_start, oe_start, led_lat, frame_done}); end
    checks++; if ({row_addr, bit_counter} !== 7'd0) begin
      failures++; $display("FAIL reset_display: got %0d expected 0", {row_addr, bit_counter}); end
    checks++; if ({shift_row, shift_bit} !== 7'd0) begin
      failures++; $display("FAIL reset_shift_pair: got %0d expected 0", {shift_row, shift_bit}); end
  endtask

  task automatic test_first_pair();
    bit ok; int t0;
    do_reset();
    @(posedge in_clk); #1 enable = 1'b1; t0 = cyc;
    wait_shifts(1, 20, ok);
    checks++; if (!ok || (shift_cyc[0] - t0) != 2) begin
      failures++; $display("FAIL first_shift_latency: got %0d expected 2", ok ? shift_cyc[0] - t0 : -1); end
    checks++; if (!ok || shift_log[0] != 0) begin
      failures++; $display("FAIL first_shift_pair: got %0d expected 0", ok ? shift_log[0] : -1); end
    wait_oes(1, 200, ok);
    checks++; if (!ok || oe_log[0] != 0) begin
      failures++; $display("FAIL first_oe_pair: got %0d expected 0", ok ? oe_log[0] : -1); end
    checks++; if (lat_widths.size() < 1 || lat_widths[0] != LW) begin
      failures++; $display("FAIL first_lat_width: got %0d expected %0d", lat_widths.size() ? lat_widths[0] : -1, LW); end
  endtask

  task automatic test_overlap();
    bit ok;
    do_reset();
    oe_fix = 40;
    @(posedge in_clk); #1 enable = 1'b1;
    wait_shifts(2, 400, ok);
    checks++; if (!ok || shift_log[1] != 1 || shift_oebusy[1] != 1) begin
      failures++; $display("FAIL overlap_second_shift: got pair %0d oe_busy %0d expected pair 1 oe_busy 1",
                           ok ? shift_log[1] : -1, ok ? shift_oebusy[1] : -1); end
    wait_oes(3, 600, ok);
    checks++; if (!ok || oe_log[1] != 1 || oe_log[2] != 2) begin
      failures++; $display("FAIL overlap_oe_order: got %0d,%0d expected 1,2", ok ? oe_log[1] : -1, ok ? oe_log[2] : -1); end
    checks++; if (overlap_cnt != 0 || oe_busy_cnt != 0) begin
      failures++; $display("FAIL overlap_lat_vs_oe: got overlap %0d oe_while_busy %0d expected 0 0", overlap_cnt, oe_busy_cnt); end
    oe_fix = 0;
  endtask

  task automatic test_full_frame();
    bit ok; int bad, fd_cnt, exp;
    do_reset();
    @(posedge in_clk); #1 enable = 1'b1;
    wait_oes(10, 1000, ok);
`ifdef AL422_BAM_SEQ_VSYNC_EN
    @(posedge in_clk); #1 vsync = 1'b1;
    @(posedge in_clk); #1 vsync = 1'b0;
`endif
    wait_oes(NPAIRS + 1, 10000, ok);
    checks++; if (!ok) begin
      failures++; $display("FAIL frame_timeout: got %0d oe_start expected %0d", oe_log.size(), NPAIRS + 1); end
    bad = 0; fd_cnt = 0;
    for (int i = 0; i < oe_log.size() && i <= NPAIRS; i++) begin
      exp = (i % NPAIRS) + (((i % NPAIRS) == NPAIRS - 1) ? 1000 : 0);
      if (oe_log[i] >= 1000 && i < NPAIRS) fd_cnt++;
      checks++; if (oe_log[i] != exp) begin
        failures++; $display("FAIL frame_oe_seq[%0d]: got %0d expected %0d", i, oe_log[i], exp); end
    end
    checks++; if (fd_cnt != 1 || oe_log.size() < NPAIRS || oe_log[NPAIRS-1] != 1000 + NPAIRS - 1) begin
      failures++; $display("FAIL frame_done_once: got count %0d expected 1 at pair %0d", fd_cnt, NPAIRS - 1); end
    for (int i = 0; i < shift_log.size() && i <= NPAIRS; i++) if (shift_log[i] != i % NPAIRS) bad++;
    checks++; if (bad != 0 || shift_log.size() < NPAIRS + 1 || shift_log[NPAIRS] != 0) begin
      failures++; $display("FAIL frame_shift_seq: got %0d bad entries expected 0", bad); end
    bad = 0;
    foreach (lat_widths[i]) if (lat_widths[i] != LW) bad++;
    checks++; if (bad != 0) begin
      failures++; $display("FAIL frame_lat_width: got %0d wrong widths expected 0", bad); end
    checks++; if (overlap_cnt + oe_busy_cnt + stray_fd_cnt != 0) begin
      failures++; $display("FAIL frame_protocol: got %0d/%0d/%0d expected 0/0/0", overlap_cnt, oe_busy_cnt, stray_fd_cnt); end
    checks++; if (shift_cyc.size() <= NPAIRS || shift_cyc[NPAIRS] - oe_cyc[NPAIRS-1] != EXP_GAP) begin
      failures++; $display("FAIL frame_back_to_back: got gap %0d expected %0d",
                           shift_cyc.size() > NPAIRS ? shift_cyc[NPAIRS] - oe_cyc[NPAIRS-1] : -1, EXP_GAP); end
  endtask

  task automatic test_disable();
    bit ok; int tgt;
    do_reset();
    tgt = 3 * NP + 5;
    @(posedge in_clk); #1 enable = 1'b1;
    wait_shifts(tgt + 1, 5000, ok);
    repeat (3) @(negedge in_clk);
    #1;
    checks++; if (!ok || shift_log[tgt] != tgt || shifter_busy !== 1'b1) begin
      failures++; $display("FAIL disable_setup: got pair %0d expected %0d", ok ? shift_log[tgt] : -1, tgt); end
    enable = 1'b0;
    wait_oes(tgt + 1, 500, ok);
    checks++; if (!ok || oe_log[tgt] != tgt) begin
      failures++; $display("FAIL disable_inflight_oe: got %0d expected %0d", ok ? oe_log[tgt] : -1, tgt); end
    repeat (60) @(negedge in_clk);
    #1;
    checks++; if (shift_log.size() != tgt + 1 || oe_log.size() != tgt + 1) begin
      failures++; $display("FAIL disable_idle: got %0d shifts %0d oes expected %0d", shift_log.size(), oe_log.size(), tgt + 1); end
    checks++; if (row_addr !== 4'd3 || bit_counter !== 3'd5) begin
      failures++; $display("FAIL disable_hold: got row %0d bit %0d expected 3 5", row_addr, bit_counter); end
    enable = 1'b1;
    wait_shifts(tgt + 2, 20, ok);
    checks++; if (!ok || shift_log[tgt+1] != 0) begin
      failures++; $display("FAIL disable_restart: got %0d expected 0", ok ? shift_log[tgt+1] : -1); end
  endtask

  task automatic test_reset_in_latch();
    bit ok;
    do_reset();
    @(posedge in_clk); #1 enable = 1'b1;
    wait_oes(3, 1000, ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge in_clk); #1; ok = (led_lat === 1'b1); end
    checks++; if (!ok) begin failures++; $display("FAIL latch_reach: got led_lat 0 expected 1"); end
    in_nrst = 1'b0;
    #1;
    checks++; if ({led_lat, oe_start, shifter_start} !== 3'b000 || row_addr !== 4'd0) begin
      failures++; $display("FAIL reset_in_latch: got %b row %0d expected 000 row 0", {led_lat, oe_start, shifter_start}, row_addr); end
    repeat (2) @(negedge in_clk);
    @(posedge in_clk); #1 in_nrst = 1'b1;
    clear_logs();
    wait_shifts(1, 20, ok);
    checks++; if (!ok || shift_log[0] != 0) begin
      failures++; $display("FAIL reset_restart: got %0d expected 0", ok ? shift_log[0] : -1); end
  endtask

`ifdef AL422_BAM_SEQ_VSYNC_EN
  task automatic test_vsync();
    bit ok;
    do_reset();
    @(posedge in_clk); #1 enable = 1'b1;
    wait_oes(NPAIRS, 10000, ok);
    repeat (100) @(negedge in_clk);
    #1;
    checks++; if (!ok || shift_log.size() != NPAIRS) begin
      failures++; $display("FAIL vsync_hold: got %0d shifts expected %0d", shift_log.size(), NPAIRS); end
    @(posedge in_clk); #1 vsync = 1'b1;
    @(posedge in_clk); #1 vsync = 1'b0;
    wait_shifts(NPAIRS + 1, 5, ok);
    checks++; if (!ok || shift_log[NPAIRS] != 0) begin
      failures++; $display("FAIL vsync_release: got %0d expected 0", ok ? shift_log[NPAIRS] : -1); end
  endtask
`endif

  initial begin
    in_nrst = 1'b0; enable = 1'b0;
    test_reset();
    test_first_pair();
    test_overlap();
    test_full_frame();
    test_disable();
    test_reset_in_latch();
`ifdef AL422_BAM_SEQ_VSYNC_EN
    test_vsync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
